mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MEM_WAIT_EN, default 1, meaning: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-003 Parameter MAX_WAIT, default 15, meaning: wait cycles allowed on memory before bus_err (range 1..255).
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Ports: Op  in  6  opcode from IR. Funct  in  6  funct from IR. Zero  in  1  ALU zero flag. mem_ready  in  1  memory access complete.
REQ-007 Ports: PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrcA (0 rs / 1 shamt), ALUSrcB (0 rt / 1 imm)  out  1 each.
REQ-008 Ports: ALUOp  out  4. NPCOp  out  2 (00 +4, 01 branch, 10 jump, 11 jr). GPRSel  out  2 (00 rd, 01 rt, 10 r31). WDSel  out  2 (00 ALU, 01 MEM, 10 PC).
REQ-009 Ports: state  out  3  current FSM state. illegal  out  1  one-cycle pulse on an undecoded instruction. bus_err  out  1  one-cycle pulse on a memory timeout.

Function
REQ-010 The FSM SHALL have states IF=0, ID=1, EX=2, MEM=3, WB=4, with all outputs decoded from the state plus Op, Funct and Zero.
REQ-011 The supported instruction set SHALL be: add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl, sllv, srlv, jr, jalr, addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
REQ-012 ALUOp codes SHALL be: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, SLL 0111, NOR 1000, LUI 1001, SRL 1010, SLLV 1011, SRLV 1100.
REQ-013 IF SHALL assert MemRead; on mem_ready it SHALL assert IRWrite and PCWrite with NPCOp=00 for one cycle and go to ID, otherwise it SHALL hold in IF.
REQ-014 ID with j/jal/jr/jalr SHALL assert PCWrite with NPCOp 10/10/11/11 and go to IF; jal and jalr SHALL also assert RegWrite, with jal using GPRSel=10, jalr using GPRSel=00, and both using WDSel=10.
REQ-015 ID with an undecoded Op/Funct SHALL pulse illegal, assert no write enable and go to IF; every other instruction SHALL go to EX.
REQ-016 In EX, beq/bne SHALL drive ALUOp=SUB and NPCOp=01, assert PCWrite only when (beq&Zero)|(bne&~Zero), and go to IF.
REQ-017 In EX, lw/sw SHALL go to MEM and all other instructions SHALL go to WB.
REQ-018 MEM with lw SHALL assert MemRead until mem_ready, then go to WB.
REQ-019 MEM with sw SHALL assert MemWrite until mem_ready, then go to IF.
REQ-020 WB SHALL assert RegWrite for exactly one cycle, with GPRSel=01 for I-type and 00 for R-type, WDSel=01 for lw and 00 otherwise, then go to IF.
REQ-021 ALUSrcA=1 only for sll/srl; ALUSrcB=1 for addi, andi, ori, slti, lui, lw, sw; EXTOp=1 for addi, slti, lui, lw, sw, andi.
REQ-022 ALUOp, ALUSrcA/B and EXTOp SHALL be held stable across EX, MEM and WB.
REQ-023 A wait counter SHALL count consecutive IF/MEM cycles with mem_ready=0 and clear on mem_ready or on a state change.
REQ-024 When the wait counter reaches MAX_WAIT, the block SHALL pulse bus_err, suppress every write enable in that cycle, clear the counter, and go to IF; an IF timeout SHALL refetch the same PC.
REQ-025 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win.

Reset
REQ-026 While rst=1, the next state SHALL be IF, the wait counter SHALL be 0, and PCWrite, IRWrite, RegWrite, MemWrite, illegal and bus_err SHALL be forced to 0.
REQ-027 Reset asserted in any state, including mid-MEM, SHALL abandon the instruction with no register or memory write.

Structure
REQ-028 Package mc_ctrl_pkg SHALL hold the state encodings and the ALUOp, NPCOp, GPRSel and WDSel constants.
REQ-029 The combinational per-instruction decode SHALL be a sub-module insn_dec (Op, Funct -> one-hot instruction flags plus valid); mc_ctrl SHALL hold the FSM and the wait counter.

Verification
REQ-030 Scenario: addu (Op=0, Funct=0x21), mem_ready=1 -> states IF,ID,EX,WB,IF; RegWrite=1 only in WB; ALUOp=0001; GPRSel=00.
REQ-031 Scenario: lw (Op=0x23) with mem_ready=0 for 3 MEM cycles -> MEM held 4 cycles; in WB, WDSel=01 and GPRSel=01; 8 cycles total.
REQ-032 Scenario: beq (Op=0x04) with Zero=1 -> in EX, PCWrite=1 and NPCOp=01; with Zero=0 -> PCWrite=0; either way 3 cycles back to IF.
REQ-033 Scenario: jal (Op=0x03) -> in ID, PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10; next state IF.
REQ-034 Scenario: MAX_WAIT=4 with mem_ready=0 in IF -> bus_err pulses in the 4th wait cycle, IRWrite=0 throughout, and the block refetches.
REQ-035 Scenario: Op=0x3F -> illegal pulses in ID; rst during sw MEM -> IF next cycle with MemWrite=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, datapath select codes,
// opcode/funct values and the one-hot instruction flag bundle.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'b0000, ALU_ADD  = 4'b0001, ALU_SUB  = 4'b0010,
                           ALU_AND  = 4'b0011, ALU_OR   = 4'b0100, ALU_SLT  = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111, ALU_NOR  = 4'b1000,
                           ALU_LUI  = 4'b1001, ALU_SRL  = 4'b1010, ALU_SLLV = 4'b1011,
                           ALU_SRLV = 4'b1100;

    localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;
    localparam logic [1:0] GPR_RD  = 2'b00, GPR_RT = 2'b01, GPR_R31 = 2'b10;
    localparam logic [1:0] WD_ALU  = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                           OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SLLV = 6'h04, FN_SRLV = 6'h06,
                           FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                           FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    typedef struct packed {
        logic i_add, i_addu, i_sub, i_subu, i_and, i_or, i_nor, i_slt, i_sltu;
        logic i_sll, i_srl, i_sllv, i_srlv, i_jr, i_jalr;
        logic i_addi, i_andi, i_ori, i_slti, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    } insn_t;

    function automatic logic [3:0] alu_op_of(input insn_t i);
        logic [3:0] r;
        r = ALU_NOP;
        if (i.i_add | i.i_addu | i.i_addi | i.i_lw | i.i_sw) r = ALU_ADD;
        if (i.i_sub | i.i_subu | i.i_beq | i.i_bne)          r = ALU_SUB;
        if (i.i_and | i.i_andi)                              r = ALU_AND;
        if (i.i_or | i.i_ori)                                r = ALU_OR;
        if (i.i_nor)                                         r = ALU_NOR;
        if (i.i_slt | i.i_slti)                              r = ALU_SLT;
        if (i.i_sltu)                                        r = ALU_SLTU;
        if (i.i_sll)                                         r = ALU_SLL;
        if (i.i_srl)                                         r = ALU_SRL;
        if (i.i_sllv)                                        r = ALU_SLLV;
        if (i.i_srlv)                                        r = ALU_SRLV;
        if (i.i_lui)                                         r = ALU_LUI;
        return r;
    endfunction

endpackage

// File: rtl/insn_dec.sv
// Combinational instruction decoder: Op/Funct to one-hot instruction flags.
// valid is low for any encoding outside the supported set.
module insn_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output insn_t      insn,
    output logic       valid
);

    always_comb begin
        insn = '0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  insn.i_add  = 1'b1;
                FN_ADDU: insn.i_addu = 1'b1;
                FN_SUB:  insn.i_sub  = 1'b1;
                FN_SUBU: insn.i_subu = 1'b1;
                FN_AND:  insn.i_and  = 1'b1;
                FN_OR:   insn.i_or   = 1'b1;
                FN_NOR:  insn.i_nor  = 1'b1;
                FN_SLT:  insn.i_slt  = 1'b1;
                FN_SLTU: insn.i_sltu = 1'b1;
                FN_SLL:  insn.i_sll  = 1'b1;
                FN_SRL:  insn.i_srl  = 1'b1;
                FN_SLLV: insn.i_sllv = 1'b1;
                FN_SRLV: insn.i_srlv = 1'b1;
                FN_JR:   insn.i_jr   = 1'b1;
                FN_JALR: insn.i_jalr = 1'b1;
                default: ;
            endcase
        end else begin
            case (op)
                OP_ADDI: insn.i_addi = 1'b1;
                OP_ANDI: insn.i_andi = 1'b1;
                OP_ORI:  insn.i_ori  = 1'b1;
                OP_SLTI: insn.i_slti = 1'b1;
                OP_LUI:  insn.i_lui  = 1'b1;
                OP_LW:   insn.i_lw   = 1'b1;
                OP_SW:   insn.i_sw   = 1'b1;
                OP_BEQ:  insn.i_beq  = 1'b1;
                OP_BNE:  insn.i_bne  = 1'b1;
                OP_J:    insn.i_j    = 1'b1;
                OP_JAL:  insn.i_jal  = 1'b1;
                default: ;
            endcase
        end
    end

    assign valid = |insn;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: IF/ID/EX/MEM/WB FSM with a memory wait
// counter that raises bus_err and abandons the access after MAX_WAIT stalled cycles.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int MAX_WAIT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       EXTOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       bus_err
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    insn_t      insn;
    logic       insn_vld;
    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       src_a_q, src_a_d, src_b_q, src_b_d, ext_q, ext_d;
    logic       mem_done, wait_done, in_exec, is_itype;

    insn_dec u_dec (
        .op    (Op),
        .funct (Funct),
        .insn  (insn),
        .valid (insn_vld)
    );

    assign mem_done  = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign wait_done = (wait_q == WAIT_LAST);
    assign is_itype  = insn.i_addi | insn.i_andi | insn.i_ori | insn.i_slti | insn.i_lui | insn.i_lw;

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        alu_op_d = alu_op_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        ext_d    = ext_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        NPCOp    = NPC_PC4;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_ID;
                end else if (wait_done) begin
                    bus_err = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_ID: begin
                // Capture ALU controls so they stay frozen through EX/MEM/WB.
                alu_op_d = alu_op_of(insn);
                src_a_d  = insn.i_sll | insn.i_srl;
                src_b_d  = is_itype | insn.i_sw;
                ext_d    = insn.i_addi | insn.i_slti | insn.i_lui | insn.i_lw | insn.i_sw | insn.i_andi;
                state_d  = S_IF;
                if (!insn_vld) begin
                    illegal = 1'b1;
                end else if (insn.i_j | insn.i_jal) begin
                    PCWrite  = 1'b1;
                    NPCOp    = NPC_JUMP;
                    RegWrite = insn.i_jal;
                    GPRSel   = GPR_R31;
                    WDSel    = WD_PC;
                end else if (insn.i_jr | insn.i_jalr) begin
                    PCWrite  = 1'b1;
                    NPCOp    = NPC_JR;
                    RegWrite = insn.i_jalr;
                    WDSel    = WD_PC;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (insn.i_beq | insn.i_bne) begin
                    NPCOp   = NPC_BRANCH;
                    PCWrite = (insn.i_beq & Zero) | (insn.i_bne & ~Zero);
                    state_d = S_IF;
                end else if (insn.i_lw | insn.i_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                MemRead  = insn.i_lw;
                MemWrite = insn.i_sw;
                if (mem_done) begin
                    state_d = insn.i_lw ? S_WB : S_IF;
                end else if (wait_done) begin
                    MemWrite = 1'b0;
                    bus_err  = 1'b1;
                    state_d  = S_IF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                GPRSel   = is_itype ? GPR_RT : GPR_RD;
                WDSel    = insn.i_lw ? WD_MEM : WD_ALU;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
            bus_err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
        alu_op_q <= alu_op_d;
        src_a_q  <= src_a_d;
        src_b_q  <= src_b_d;
        ext_q    <= ext_d;
    end

    assign in_exec = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);
    assign ALUOp   = in_exec ? alu_op_q : ALU_NOP;
    assign ALUSrcA = in_exec & src_a_q;
    assign ALUSrcB = in_exec & src_b_q;
    assign EXTOp   = in_exec & ext_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: walks each instruction through its expected life cycle
// (fetch, decode, execute, memory, write-back) with random stalls and opcodes.
module tb_mc_ctrl;

    localparam int MAXW = 4;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_ILL = 10;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic [3:0] alu;
        logic       a, b, x;
        logic [3:0] kind;
    } ent_t;

    logic clk, rst, Zero, mem_ready;
    logic [5:0] Op, Funct;
    logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic [2:0] state;
    logic illegal, bus_err;

    int vectors = 0;
    int miscompares = 0;
    ent_t  tbl[$];
    string names[$];
    string cur;
    logic [5:0] s_op, s_funct;
    logic s_rst;

    int e_state, e_pcw, e_irw, e_rw, e_mr, e_mw, e_ill, e_bus, e_npc, e_gpr, e_wd;
    int e_alu, e_a, e_b, e_x;
    bit e_npc_chk, e_alu_chk;

    mc_ctrl #(.MEM_WAIT_EN(1), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
        .illegal(illegal), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic def(input string n, input logic [5:0] op, input logic [5:0] fn,
                       input logic [3:0] alu, input logic a, input logic b, input logic x,
                       input int k);
        ent_t t;
        t.op = op; t.funct = fn; t.alu = alu; t.a = a; t.b = b; t.x = x; t.kind = 4'(k);
        tbl.push_back(t);
        names.push_back(n);
    endtask

    function automatic int find(input string n);
        foreach (names[i]) if (names[i] == n) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s/%s observed=%0d expected=%0d", cur, tag, obs, exp);
        end
    endtask

    task automatic exp_idle();
        e_state = 0; e_pcw = 0; e_irw = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_ill = 0;
        e_bus = 0; e_npc = 0; e_gpr = 0; e_wd = 0; e_npc_chk = 0; e_alu_chk = 0;
        e_alu = 0; e_a = 0; e_b = 0; e_x = 0;
    endtask

    task automatic set_alu(input ent_t e);
        e_alu_chk = 1; e_alu = int'(e.alu); e_a = int'(e.a); e_b = int'(e.b); e_x = int'(e.x);
    endtask

    // Drive one cycle's inputs on the falling edge, then compare settled outputs.
    task automatic step(input logic rdy, input logic z, input string tag);
        @(negedge clk);
        rst = s_rst; Op = s_op; Funct = s_funct; mem_ready = rdy; Zero = z;
        #1;
        chk({tag, ".state"},   32'(state),    32'(e_state));
        chk({tag, ".PCWrite"}, 32'(PCWrite),  32'(e_pcw));
        chk({tag, ".IRWrite"}, 32'(IRWrite),  32'(e_irw));
        chk({tag, ".RegWrite"},32'(RegWrite), 32'(e_rw));
        chk({tag, ".MemRead"}, 32'(MemRead),  32'(e_mr));
        chk({tag, ".MemWrite"},32'(MemWrite), 32'(e_mw));
        chk({tag, ".illegal"}, 32'(illegal),  32'(e_ill));
        chk({tag, ".bus_err"}, 32'(bus_err),  32'(e_bus));
        if (e_pcw != 0 || e_npc_chk) chk({tag, ".NPCOp"}, 32'(NPCOp), 32'(e_npc));
        if (e_rw != 0) begin
            chk({tag, ".GPRSel"}, 32'(GPRSel), 32'(e_gpr));
            chk({tag, ".WDSel"},  32'(WDSel),  32'(e_wd));
        end
        if (e_alu_chk) begin
            chk({tag, ".ALUOp"},   32'(ALUOp),   32'(e_alu));
            chk({tag, ".ALUSrcA"}, 32'(ALUSrcA), 32'(e_a));
            chk({tag, ".ALUSrcB"}, 32'(ALUSrcB), 32'(e_b));
            chk({tag, ".EXTOp"},   32'(EXTOp),   32'(e_x));
        end
    endtask

    // Fetch with 'waits' stalled cycles; MAXW or more stalls time out and refetch.
    task automatic fetch(input int waits);
        for (int w = 0; w < waits && w < MAXW; w++) begin
            exp_idle(); e_mr = 1; e_bus = (w == MAXW - 1) ? 1 : 0;
            step(1'b0, 1'($urandom), $sformatf("if_wait%0d", w));
        end
        exp_idle(); e_mr = 1; e_irw = 1; e_pcw = 1; e_npc = 0;
        step(1'b1, 1'($urandom), "if_fetch");
    endtask

    task automatic run_insn(input int idx, input logic z, input int if_wait, input int mem_wait);
        ent_t e;
        int k;
        e = tbl[idx];
        k = int'(e.kind);
        cur = names[idx];
        s_op = e.op;
        s_funct = (e.op == 6'h00) ? e.funct : 6'($urandom);
        fetch(if_wait);
        exp_idle(); e_state = 1;
        if (k == K_ILL) e_ill = 1;
        if (k == K_J || k == K_JAL) begin e_pcw = 1; e_npc = 2; end
        if (k == K_JR || k == K_JALR) begin e_pcw = 1; e_npc = 3; end
        if (k == K_JAL) begin e_rw = 1; e_gpr = 2; e_wd = 2; end
        if (k == K_JALR) begin e_rw = 1; e_gpr = 0; e_wd = 2; end
        step(1'($urandom), 1'($urandom), "id");
        if (k >= K_J) return;
        exp_idle(); e_state = 2; set_alu(e);
        if (k == K_BEQ || k == K_BNE) begin
            e_npc_chk = 1; e_npc = 1;
            e_pcw = (k == K_BEQ) ? int'(z) : int'(!z);
            step(1'($urandom), z, "ex");
            return;
        end
        step(1'($urandom), 1'($urandom), "ex");
        if (k == K_LW || k == K_SW) begin
            for (int w = 0; w < mem_wait && w < MAXW; w++) begin
                exp_idle(); e_state = 3; set_alu(e);
                e_mr = (k == K_LW) ? 1 : 0;
                e_mw = (k == K_SW && w != MAXW - 1) ? 1 : 0;
                e_bus = (w == MAXW - 1) ? 1 : 0;
                step(1'b0, 1'($urandom), $sformatf("mem_wait%0d", w));
            end
            if (mem_wait >= MAXW) return;
            exp_idle(); e_state = 3; set_alu(e);
            e_mr = (k == K_LW) ? 1 : 0;
            e_mw = (k == K_SW) ? 1 : 0;
            step(1'b1, 1'($urandom), "mem_done");
            if (k == K_SW) return;
        end
        exp_idle(); e_state = 4; set_alu(e); e_rw = 1;
        e_gpr = (k == K_I || k == K_LW) ? 1 : 0;
        e_wd  = (k == K_LW) ? 1 : 0;
        step(1'($urandom), 1'($urandom), "wb");
    endtask

    initial begin
        int r, iw, mw;
        def("add",  6'h00, 6'h20, 4'b0001, 0, 0, 0, K_R);
        def("addu", 6'h00, 6'h21, 4'b0001, 0, 0, 0, K_R);
        def("sub",  6'h00, 6'h22, 4'b0010, 0, 0, 0, K_R);
        def("subu", 6'h00, 6'h23, 4'b0010, 0, 0, 0, K_R);
        def("and",  6'h00, 6'h24, 4'b0011, 0, 0, 0, K_R);
        def("or",   6'h00, 6'h25, 4'b0100, 0, 0, 0, K_R);
        def("nor",  6'h00, 6'h27, 4'b1000, 0, 0, 0, K_R);
        def("slt",  6'h00, 6'h2A, 4'b0101, 0, 0, 0, K_R);
        def("sltu", 6'h00, 6'h2B, 4'b0110, 0, 0, 0, K_R);
        def("sll",  6'h00, 6'h00, 4'b0111, 1, 0, 0, K_R);
        def("srl",  6'h00, 6'h02, 4'b1010, 1, 0, 0, K_R);
        def("sllv", 6'h00, 6'h04, 4'b1011, 0, 0, 0, K_R);
        def("srlv", 6'h00, 6'h06, 4'b1100, 0, 0, 0, K_R);
        def("jr",   6'h00, 6'h08, 4'b0000, 0, 0, 0, K_JR);
        def("jalr", 6'h00, 6'h09, 4'b0000, 0, 0, 0, K_JALR);
        def("addi", 6'h08, 6'h00, 4'b0001, 0, 1, 1, K_I);
        def("andi", 6'h0C, 6'h00, 4'b0011, 0, 1, 1, K_I);
        def("ori",  6'h0D, 6'h00, 4'b0100, 0, 1, 0, K_I);
        def("slti", 6'h0A, 6'h00, 4'b0101, 0, 1, 1, K_I);
        def("lui",  6'h0F, 6'h00, 4'b1001, 0, 1, 1, K_I);
        def("lw",   6'h23, 6'h00, 4'b0001, 0, 1, 1, K_LW);
        def("sw",   6'h2B, 6'h00, 4'b0001, 0, 1, 1, K_SW);
        def("beq",  6'h04, 6'h00, 4'b0010, 0, 0, 0, K_BEQ);
        def("bne",  6'h05, 6'h00, 4'b0010, 0, 0, 0, K_BNE);
        def("j",    6'h02, 6'h00, 4'b0000, 0, 0, 0, K_J);
        def("jal",  6'h03, 6'h00, 4'b0000, 0, 0, 0, K_JAL);
        def("ill3f",   6'h3F, 6'h00, 4'b0000, 0, 0, 0, K_ILL);
        def("ill20",   6'h20, 6'h00, 4'b0000, 0, 0, 0, K_ILL);
        def("illfn01", 6'h00, 6'h01, 4'b0000, 0, 0, 0, K_ILL);
        def("illxor",  6'h00, 6'h26, 4'b0000, 0, 0, 0, K_ILL);

        s_rst = 1'b1; rst = 1'b1; s_op = 6'h00; s_funct = 6'h21;
        Op = s_op; Funct = s_funct; Zero = 1'b0; mem_ready = 1'b0;

        cur = "reset";
        exp_idle(); e_mr = 1;
        step(1'b1, 1'b0, "rst0");
        step(1'b1, 1'b1, "rst1");
        s_rst = 1'b0;

        run_insn(find("addu"), 1'b0, 0, 0);
        run_insn(find("lw"),   1'b0, 0, 3);
        run_insn(find("beq"),  1'b1, 0, 0);
        run_insn(find("beq"),  1'b0, 0, 0);
        run_insn(find("bne"),  1'b0, 0, 0);
        run_insn(find("jal"),  1'b0, 0, 0);
        run_insn(find("jalr"), 1'b0, 0, 0);
        run_insn(find("addu"), 1'b0, MAXW, 0);
        run_insn(find("ill3f"), 1'b0, 0, 0);
        run_insn(find("sw"),   1'b0, 0, MAXW);
        run_insn(find("lw"),   1'b0, 2, MAXW);

        // Reset asserted while a store is stalled in MEM.
        cur = "sw_rst";
        s_op = 6'h2B; s_funct = 6'h00;
        fetch(0);
        exp_idle(); e_state = 1;
        step(1'b0, 1'b0, "id");
        exp_idle(); e_state = 2; set_alu(tbl[find("sw")]);
        step(1'b0, 1'b0, "ex");
        exp_idle(); e_state = 3; set_alu(tbl[find("sw")]); e_mw = 1;
        step(1'b0, 1'b0, "mem_wait0");
        s_rst = 1'b1;
        exp_idle(); e_state = 3; set_alu(tbl[find("sw")]);
        step(1'b0, 1'b0, "mem_rst");
        s_rst = 1'b0;
        run_insn(find("addi"), 1'b0, 0, 0);

        for (int n = 0; n < 90; n++) begin
            r  = int'($urandom_range(0, 9));
            iw = (r < 6) ? 0 : r - 5;
            r  = int'($urandom_range(0, 9));
            mw = (r < 5) ? 0 : r - 5;
            run_insn(int'($urandom_range(0, tbl.size() - 1)), 1'($urandom), iw, mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
